// File: rtl/nn_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_game_pkg
// Description : Shared definitions for the game datapath: direction codes,
//               move-controller state encoding, default grid size and a
//               reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_game_pkg;

  // Direction codes as produced by neural_network
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Default playfield size in cells
  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;

  // Move-controller sequence states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SENSE  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_MOVE   = 2'd3
  } move_state_t;

  // Opposite directions differ only in bit 1 of the encoding
  function automatic logic is_reversal(input logic [1:0] req_dir,
                                       input logic [1:0] cur_dir);
    return req_dir == (cur_dir ^ 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : nn_tick_gen
// Description : Game-tick divider. Counts enabled clk cycles and emits a
//               one-cycle tick while the counter sits on its last value;
//               the count freezes whenever en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

  // The move sequence needs four cycles, so a shorter period would drop ticks
  generate
    if (TICK_DIV < 4) begin : g_tick_div_check
      $error("nn_tick_gen: TICK_DIV must be at least 4");
    end
  endgenerate

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_last);
  assign tick      = en & w_at_last;

  // Free-running divider, held while the game is paused
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nn_move_ctrl
// Description : Per-tick move sequencer behind neural_network. Requests a
//               sensor snapshot, samples the 2-bit decision after one settle
//               cycle, rejects 180-degree reversals and steps the head one
//               cell. Outputs are registered.
//               Build option NN_MOVE_WRAP_EN: grid edges wrap around and
//               hit_wall is tied low. Without it, a step off the grid keeps
//               the head in place and sets the sticky hit_wall flag.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_move_ctrl
  import nn_game_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 25000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [1:0]     nn_dir,
  output logic           sense_req,
  output logic [1:0]     cur_dir,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           step_valid,
  output logic           hit_wall
);

  localparam logic [X_W-1:0] c_x_max  = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] c_y_max  = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] c_x_home = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0] c_y_home = Y_W'(GRID_H / 2);

  generate
    if (GRID_W < 2 || GRID_H < 2) begin : g_grid_check
      $error("nn_move_ctrl: grid must be at least 2x2");
    end
    if ((64'd1 << X_W) < 64'(GRID_W) || (64'd1 << Y_W) < 64'(GRID_H)) begin : g_width_check
      $error("nn_move_ctrl: X_W/Y_W too narrow for the grid");
    end
  endgenerate

  logic           w_tick;
  move_state_t    r_state, w_state_nxt;
  logic [1:0]     r_cur_dir, w_cur_dir_nxt, w_move_dir;
  logic [X_W-1:0] r_head_x, w_head_x_nxt, w_step_x;
  logic [Y_W-1:0] r_head_y, w_head_y_nxt, w_step_y;
  logic           r_sense_req, w_sense_req_nxt;
  logic           r_step_valid, w_step_valid_nxt;
  logic           r_hit_wall, w_hit_wall_nxt;
  logic           w_off_grid;

  nn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  // Candidate head position for the current decision, with edge detection
  always_comb begin
    w_move_dir = is_reversal(nn_dir, r_cur_dir) ? r_cur_dir : nn_dir;
    w_step_x   = r_head_x;
    w_step_y   = r_head_y;
    w_off_grid = 1'b0;
    case (w_move_dir)
      DIR_UP: begin
        if (r_head_y == '0) begin
`ifdef NN_MOVE_WRAP_EN
          w_step_y = c_y_max;
`else
          w_off_grid = 1'b1;
`endif
        end else begin
          w_step_y = r_head_y - Y_W'(1);
        end
      end
      DIR_DOWN: begin
        if (r_head_y == c_y_max) begin
`ifdef NN_MOVE_WRAP_EN
          w_step_y = '0;
`else
          w_off_grid = 1'b1;
`endif
        end else begin
          w_step_y = r_head_y + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (r_head_x == '0) begin
`ifdef NN_MOVE_WRAP_EN
          w_step_x = c_x_max;
`else
          w_off_grid = 1'b1;
`endif
        end else begin
          w_step_x = r_head_x - X_W'(1);
        end
      end
      default: begin
        if (r_head_x == c_x_max) begin
`ifdef NN_MOVE_WRAP_EN
          w_step_x = '0;
`else
          w_off_grid = 1'b1;
`endif
        end else begin
          w_step_x = r_head_x + X_W'(1);
        end
      end
    endcase
  end

  // Sequencer next state and next register values. The decision is sampled
  // on the DECIDE->MOVE edge, so the new head is visible during MOVE.
  always_comb begin
    w_state_nxt      = r_state;
    w_sense_req_nxt  = 1'b0;
    w_step_valid_nxt = 1'b0;
    w_cur_dir_nxt    = r_cur_dir;
    w_head_x_nxt     = r_head_x;
    w_head_y_nxt     = r_head_y;
    w_hit_wall_nxt   = r_hit_wall;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !r_hit_wall) begin
          w_state_nxt     = ST_SENSE;
          w_sense_req_nxt = 1'b1;
        end
      end
      ST_SENSE: begin
        w_state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        w_state_nxt      = ST_MOVE;
        w_step_valid_nxt = 1'b1;
        w_cur_dir_nxt    = w_move_dir;
        w_head_x_nxt     = w_step_x;
        w_head_y_nxt     = w_step_y;
        if (w_off_grid) begin
          w_hit_wall_nxt = 1'b1;
        end
      end
      ST_MOVE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cur_dir    <= DIR_RIGHT;
      r_head_x     <= c_x_home;
      r_head_y     <= c_y_home;
      r_sense_req  <= 1'b0;
      r_step_valid <= 1'b0;
      r_hit_wall   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_dir    <= w_cur_dir_nxt;
      r_head_x     <= w_head_x_nxt;
      r_head_y     <= w_head_y_nxt;
      r_sense_req  <= w_sense_req_nxt;
      r_step_valid <= w_step_valid_nxt;
      r_hit_wall   <= w_hit_wall_nxt;
    end
  end

  assign sense_req  = r_sense_req;
  assign cur_dir    = r_cur_dir;
  assign head_x     = r_head_x;
  assign head_y     = r_head_y;
  assign step_valid = r_step_valid;
`ifdef NN_MOVE_WRAP_EN
  assign hit_wall   = 1'b0;
`else
  assign hit_wall   = r_hit_wall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nn_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_move_ctrl
// Description : Self-checking bench for nn_move_ctrl on an 8x6 grid with a
//               four-cycle tick. Each move pushes its expected result when
//               the decision is driven; the result is popped and compared
//               when step_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_move_ctrl;

  localparam int GW = 8;
  localparam int GH = 6;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    nn_dir;
  logic          sense_req;
  logic [1:0]    cur_dir;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          step_valid;
  logic          hit_wall;

  nn_move_ctrl #(
    .GRID_W   (GW),
    .GRID_H   (GH),
    .X_W      (XW),
    .Y_W      (YW),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .nn_dir     (nn_dir),
    .sense_req  (sense_req),
    .cur_dir    (cur_dir),
    .head_x     (head_x),
    .head_y     (head_y),
    .step_valid (step_valid),
    .hit_wall   (hit_wall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int dir;
    int wall;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_x, m_y, m_dir, m_wall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = GW / 2;
    m_y = GH / 2;
    m_dir = 1;
    m_wall = 0;
  endtask

  // Reference move: reversal filter, then one step with edge handling
  task automatic model_push(input int nd);
    exp_t e;
    if (nd != (m_dir ^ 2)) m_dir = nd;
    case (m_dir)
      0: if (m_y == 0) begin
`ifdef NN_MOVE_WRAP_EN
           m_y = GH - 1;
`else
           m_wall = 1;
`endif
         end else m_y = m_y - 1;
      2: if (m_y == GH - 1) begin
`ifdef NN_MOVE_WRAP_EN
           m_y = 0;
`else
           m_wall = 1;
`endif
         end else m_y = m_y + 1;
      3: if (m_x == 0) begin
`ifdef NN_MOVE_WRAP_EN
           m_x = GW - 1;
`else
           m_wall = 1;
`endif
         end else m_x = m_x - 1;
      default: if (m_x == GW - 1) begin
`ifdef NN_MOVE_WRAP_EN
           m_x = 0;
`else
           m_wall = 1;
`endif
         end else m_x = m_x + 1;
    endcase
    e.x = m_x; e.y = m_y; e.dir = m_dir; e.wall = m_wall;
    sb_q.push_back(e);
  endtask

  task automatic compare_step(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_x"},    head_x,   e.x);
    check({tag, "_y"},    head_y,   e.y);
    check({tag, "_dir"},  cur_dir,  e.dir);
    check({tag, "_wall"}, hit_wall, e.wall);
  endtask

  task automatic wait_sense(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sense_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("sense_timeout", 0, 1);
  endtask

  task automatic wait_step(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("step_timeout", 0, 1);
  endtask

  // One full sequence: 'first' is driven up to the DECIDE cycle, 'fin'
  // during DECIDE, which is the value that must be acted upon.
  task automatic do_move(input string tag, input int first, input int fin, input bit drop_en);
    bit ok;
    exp_t dummy;
    nn_dir = 2'(first);
    model_push(fin);
    wait_sense(ok);
    if (!ok) begin
      dummy = sb_q.pop_front();
      return;
    end
    if (drop_en) en = 1'b0;
    @(negedge clk);
    check({tag, "_sense_one_cycle"}, sense_req, 0);
    nn_dir = 2'(fin);
    wait_step(ok);
    if (!ok) begin
      dummy = sb_q.pop_front();
      return;
    end
    compare_step(tag);
    @(negedge clk);
    check({tag, "_step_one_cycle"}, step_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sense_cyc, step_cyc, cnt;
    exp_t dummy;

    // Reset state
    rst_n = 1'b0; en = 1'b0; nn_dir = 2'd1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_x",     head_x,     4);
    check("rst_y",     head_y,     3);
    check("rst_dir",   cur_dir,    1);
    check("rst_sense", sense_req,  0);
    check("rst_step",  step_valid, 0);
    check("rst_wall",  hit_wall,   0);

    // First move latency from reset release
    rst_n = 1'b1; en = 1'b1; nn_dir = 2'd1;
    model_push(1);
    sense_cyc = 0; step_cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (sense_req && sense_cyc == 0) sense_cyc = c;
      if (step_valid && step_cyc == 0) begin
        step_cyc = c;
        compare_step("first");
      end
    end
    check("first_sense_cycle", sense_cyc, 4);
    check("first_step_cycle",  step_cyc,  6);
    if (step_cyc == 0 && sb_q.size() != 0) dummy = sb_q.pop_front();

    // Reversal rejected, then a legal turn
    do_move("reverse", 3, 3, 1'b0);
    do_move("turn_up", 0, 0, 1'b0);

    // Decision changes during SENSE: value at end of DECIDE wins
    do_move("late_dir", 3, 1, 1'b0);

    // en drops in SENSE: move completes, then no more sequences
    do_move("en_drop", 2, 2, 1'b1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sense_req || step_valid) cnt++;
    end
    check("paused_quiet", cnt, 0);
    en = 1'b1;

`ifdef NN_MOVE_WRAP_EN
    do_move("wrap_right", 1, 1, 1'b0);
    for (int i = 0; i < 4; i++) do_move("wrap_up", 0, 0, 1'b0);
    check("wrap_no_wall", hit_wall, 0);
`else
    do_move("wall_right", 1, 1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sense_req || step_valid) cnt++;
    end
    check("game_over_quiet", cnt, 0);
    check("wall_sticky", hit_wall, 1);
`endif

    // Reset clears state; then reset lands in DECIDE of a sequence
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst2_wall", hit_wall, 0);
    check("rst2_x",    head_x,   4);
    rst_n = 1'b1;
    do_move("post_rst", 2, 2, 1'b0);
    begin
      bit ok;
      nn_dir = 2'd3;
      wait_sense(ok);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_step", step_valid, 0);
      check("abort_x",    head_x,     4);
      check("abort_y",    head_y,     3);
      check("abort_dir",  cur_dir,    1);
      rst_n = 1'b1;
      en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (step_valid) cnt++;
      end
      check("abort_no_step", cnt, 0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nn_move_ctrl.md
Name: nn_move_ctrl

Overview:
- Downstream consumer of neural_network's 2-bit direction output (dir) in the game datapath.
- On each game tick: requests a fresh sensor snapshot from upstream, samples the network's decision, rejects 180° reversals, and advances the head position on the grid.
- Produces the registered head coordinates and a one-cycle step strobe for the renderer and collision logic.

Parameters:
- GRID_W, 32, grid width in cells (≥2)
- GRID_H, 24, grid height in cells (≥2)
- X_W, 5, width of head_x; must satisfy 2^X_W ≥ GRID_W
- Y_W, 5, width of head_y; must satisfy 2^Y_W ≥ GRID_H
- TICK_DIV, 25000000, clk cycles per move; must be ≥4, checked at elaboration

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- en  in  1  game running; freezes the tick counter when low
- nn_dir  in  2  decision from neural_network: 0=up, 1=right, 2=down, 3=left
- sense_req  out  1  one-cycle pulse; upstream latches sensors a..f on it
- cur_dir  out  2  direction actually applied on the last move
- head_x  out  X_W  head column
- head_y  out  Y_W  head row (0 = top)
- step_valid  out  1  one-cycle strobe, high when head_x/head_y first show the new position
- hit_wall  out  1  sticky wall-collision flag

Behaviour:
- Reset (rst_n=0 at a clk edge), all registered:
  - head_x=GRID_W/2, head_y=GRID_H/2, cur_dir=1 (right)
  - sense_req=0, step_valid=0, hit_wall=0
  - tick counter=0, state=IDLE
- Reset mid-sequence aborts the sequence; no step_valid is issued.
- Tick counter:
  - Increments when en=1 and holds when en=0.
  - At TICK_DIV-1 it wraps to 0 and raises tick. Tick is only acted on in IDLE; TICK_DIV≥4 guarantees this.
- FSM, all outputs registered:
  - IDLE: on tick, go to SENSE.
  - SENSE: sense_req=1 for exactly this cycle. Go to DECIDE.
  - DECIDE: gives the combinational network one settle cycle. At the end of the cycle, register nn_dir into next_dir. Go to MOVE.
  - MOVE:
    - If next_dir == cur_dir XOR 2 (reversal), keep cur_dir; otherwise cur_dir ← next_dir.
    - Apply a one-cell step in the resulting direction to head_x/head_y.
    - step_valid=1 this cycle only. Return to IDLE.
- Latency: tick cycle T → sense_req at T+1 → nn_dir sampled at end of T+2 → new head and step_valid at T+3.
- en falling mid-sequence: the sequence completes; only the counter freezes.
- Step arithmetic:
  - up: y-1; down: y+1; left: x-1; right: x+1.
  - All in X_W/Y_W-bit unsigned, with explicit edge compare. Never rely on natural power-of-2 overflow, since GRID_W/GRID_H need not be powers of two.
- Edge handling: see Optional Feature.
- hit_wall, once set, clears only on reset. While it is set, the FSM stays in IDLE (game over).

Optional Feature:
- Macro: NN_MOVE_WRAP_EN
- Defined:
  - Edges wrap: x=GRID_W-1 moving right → 0; x=0 moving left → GRID_W-1. Same for y with GRID_H.
  - hit_wall is tied 0.
- Undefined:
  - A step that would leave the grid leaves the head unchanged and sets hit_wall in that MOVE cycle.
  - step_valid still pulses for that move.

Decomposition:
- Shared package nn_game_pkg:
  - Direction constants DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - FSM state encoding: IDLE, SENSE, DECIDE, MOVE.
  - Default GRID_W/GRID_H.
- One natural sub-module: nn_tick_gen, the TICK_DIV counter with en gating that emits the one-cycle tick. Everything else stays in nn_move_ctrl.

Test Plan (TICK_DIV=4, GRID 8x6, X_W=Y_W=3):
- Reset: hold rst_n=0 for 2 cycles → head=(4,3), cur_dir=1, all strobes 0. Release with en=1, nn_dir=1 → sense_req at cycle 4, step_valid at cycle 6, head=(5,3).
- Reversal: cur_dir=1, drive nn_dir=3 → cur_dir stays 1, head x+1. Then nn_dir=0 → cur_dir=0, head y-1.
- Wrap (NN_MOVE_WRAP_EN defined): head (7,3) moving right → (0,3). Head (x,0) moving up → (x,5). hit_wall stays 0.
- Wall (macro undefined): head (7,3) moving right → head unchanged, hit_wall=1, step_valid pulses once. No further sense_req for 20 cycles.
- Timing: change nn_dir during SENSE → sampled value is the value at end of DECIDE. en=0 at SENSE → move still completes, then no sense_req while en=0.
- Reset mid-op: rst_n=0 in DECIDE → no step_valid, head returns to (4,3) next cycle.
